nec_ir_transmitter: RTL and testbench

- NEC-protocol infrared transmitter: encoder counterpart of the on-board NEC IR receiver path.
- Accepts an 8-bit address and an 8-bit command through a valid/ready handshake and serializes them into a 32-bit NEC frame.
- Drives a carrier-modulated IR LED output, plus a raw envelope output for loopback into the receiver and for scope debug.
- Sits between the key/button logic and the IR LED pin; the 50 MHz system clock is the only clock.

---
 rtl/nec_ir_transmitter.sv | 213 +++++++++++++++++++++
 tb/tb_nec_ir_transmitter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_transmitter.sv
// NEC infrared transmitter.
// Accepts an 8-bit address and command over a valid/ready handshake and sends
// them as a 32-bit NEC frame (leader, 32 pulse-distance bits LSB first, stop
// mark, then a gap that pads the frame period to FRAME_UNITS units).
// Optional feature: define NEC_REPEAT_EN to send NEC repeat codes while
// tx_repeat is held at the end of each frame period.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   tx_valid     request to send a frame
//   tx_addr      NEC address byte
//   tx_cmd       NEC command byte
//   tx_repeat    key-held indication (NEC_REPEAT_EN builds only)
//   tx_ready     high while idle; a request is accepted when valid & ready
//   tx_done      one-cycle pulse in the last cycle of each stop mark
//   ir_envelope  unmodulated mark/space envelope (1 = mark)
//   ir_tx_out    envelope gated by the carrier; drives the IR LED
module nec_ir_transmitter #(
    parameter int unsigned UNIT_CYC     = 28125,
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 439,
    parameter int unsigned FRAME_UNITS  = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    input  logic       tx_repeat,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       ir_envelope,
    output logic       ir_tx_out
);

    localparam int unsigned UNIT_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int unsigned CAR_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int unsigned PER_W  = $clog2(FRAME_UNITS * UNIT_CYC) + 1;
    localparam int unsigned DUR_W  = 5;
    localparam int unsigned BIT_W  = 5;

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYC - 1);
    localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_DIV - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(FRAME_UNITS * UNIT_CYC - 1);
    localparam logic [CAR_W:0]    CAR_HIGH  = (CAR_W + 1)'(CARRIER_HIGH);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        shreg, shreg_nxt;
    logic [BIT_W-1:0]   bit_idx, bit_nxt;
    logic [UNIT_W-1:0]  unit_cnt, unit_nxt;
    logic [DUR_W-1:0]   dur_cnt, dur_nxt;
    logic [PER_W-1:0]   per_cnt, per_nxt;
    logic [CAR_W-1:0]   car_cnt, car_nxt;
    logic [DUR_W-1:0]   dur_last;
    logic               unit_end;
    logic               seg_end;
    logic               env_nxt;
    logic               out_nxt;
    logic               ready_nxt;
    logic               done_nxt;

`ifndef NEC_REPEAT_EN
    logic unused_repeat;
    assign unused_repeat = tx_repeat;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counters and next output values.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_idx;
        unit_nxt  = unit_cnt;
        dur_nxt   = dur_cnt;
        per_nxt   = per_cnt;
        car_nxt   = car_cnt;
        dur_last  = '0;
        env_nxt   = 1'b0;
        out_nxt   = 1'b0;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;

        // Last unit index of the current state (duration minus one).
        case (state)
            LEAD_MARK,
            REP_MARK:   dur_last = DUR_W'(15);
            LEAD_SPACE: dur_last = DUR_W'(7);
            REP_SPACE:  dur_last = DUR_W'(3);
            BIT_SPACE:  dur_last = shreg[0] ? DUR_W'(2) : DUR_W'(0);
            default:    dur_last = '0;
        endcase

        unit_end = (unit_cnt == UNIT_LAST);
        seg_end  = unit_end && (dur_cnt == dur_last);

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nxt = LEAD_MARK;
                    shreg_nxt = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                    bit_nxt   = '0;
                end
            end
            LEAD_MARK:  if (seg_end) state_nxt = LEAD_SPACE;
            LEAD_SPACE: if (seg_end) state_nxt = BIT_MARK;
            BIT_MARK:   if (seg_end) state_nxt = BIT_SPACE;
            BIT_SPACE: begin
                if (seg_end) begin
                    shreg_nxt = shreg >> 1;
                    bit_nxt   = bit_idx + BIT_W'(1);
                    state_nxt = (bit_idx == BIT_W'(31)) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (seg_end) state_nxt = GAP;
            GAP: begin
                if (per_cnt == PER_LAST) begin
`ifdef NEC_REPEAT_EN
                    state_nxt = tx_repeat ? REP_MARK : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            REP_MARK:   if (seg_end) state_nxt = REP_SPACE;
            REP_SPACE:  if (seg_end) state_nxt = STOP_MARK;
            default:    state_nxt = IDLE;
        endcase

        // Unit/duration counters restart on every state change.
        if ((state_nxt != state) || (state_nxt == IDLE)) begin
            unit_nxt = '0;
            dur_nxt  = '0;
        end else if (unit_end) begin
            unit_nxt = '0;
            dur_nxt  = dur_cnt + DUR_W'(1);
        end else begin
            unit_nxt = unit_cnt + UNIT_W'(1);
        end

        // Frame period is measured from leader (or repeat mark) start.
        if ((state_nxt == IDLE) ||
            ((state_nxt != state) && ((state_nxt == LEAD_MARK) || (state_nxt == REP_MARK)))) begin
            per_nxt = '0;
        end else begin
            per_nxt = per_cnt + PER_W'(1);
        end

        env_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                  (state_nxt == STOP_MARK) || (state_nxt == REP_MARK);

        // Carrier phase restarts on each mark so every mark begins high.
        if (env_nxt && !ir_envelope) begin
            car_nxt = '0;
        end else if (car_cnt == CAR_LAST) begin
            car_nxt = '0;
        end else begin
            car_nxt = car_cnt + CAR_W'(1);
        end

        out_nxt   = env_nxt && ({1'b0, car_nxt} < CAR_HIGH);
        ready_nxt = (state_nxt == IDLE);
        done_nxt  = (state_nxt == STOP_MARK) && (unit_nxt == UNIT_LAST) && (dur_nxt == '0);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            bit_idx     <= '0;
            unit_cnt    <= '0;
            dur_cnt     <= '0;
            per_cnt     <= '0;
            car_cnt     <= '0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            ir_envelope <= 1'b0;
            ir_tx_out   <= 1'b0;
        end else begin
            shreg       <= shreg_nxt;
            bit_idx     <= bit_nxt;
            unit_cnt    <= unit_nxt;
            dur_cnt     <= dur_nxt;
            per_cnt     <= per_nxt;
            car_cnt     <= car_nxt;
            tx_ready    <= ready_nxt;
            tx_done     <= done_nxt;
            ir_envelope <= env_nxt;
            ir_tx_out   <= out_nxt;
        end
    end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed self-checking bench for nec_ir_transmitter with scaled timing
// (10 cycles per unit, carrier period 4 with 2 high cycles, 1920-cycle frame).
// Log index k is the k-th falling edge after the transfer edge, so k = 0 is
// the first cycle in which the envelope should be high.
module tb_nec_ir_transmitter;

    localparam int NMAX = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_repeat;
    logic       tx_ready;
    logic       tx_done;
    logic       ir_envelope;
    logic       ir_tx_out;

    int checks = 0;
    int errors = 0;

    logic env_log  [0:NMAX-1];
    logic out_log  [0:NMAX-1];
    logic done_log [0:NMAX-1];
    logic rdy_log  [0:NMAX-1];
    logic exp_env  [0:NMAX-1];
    logic exp_out  [0:NMAX-1];

    nec_ir_transmitter #(
        .UNIT_CYC    (10),
        .CARRIER_DIV (4),
        .CARRIER_HIGH(2),
        .FRAME_UNITS (192)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_addr    (tx_addr),
        .tx_cmd     (tx_cmd),
        .tx_repeat  (tx_repeat),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .ir_envelope(ir_envelope),
        .ir_tx_out  (ir_tx_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Start a frame, then log outputs for ncap cycles; optionally pulse a
    // second request at busy_at and drop tx_repeat at rep_off_at.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input logic rep,
                             input int rep_off_at, input int busy_at, input int ncap);
        @(negedge clk);
        tx_addr   = a;
        tx_cmd    = c;
        tx_repeat = rep;
        tx_valid  = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < ncap; k++) begin
            @(negedge clk);
            env_log[k]  = ir_envelope;
            out_log[k]  = ir_tx_out;
            done_log[k] = tx_done;
            rdy_log[k]  = tx_ready;
            if (k == busy_at) begin
                tx_addr  = 8'hFF;
                tx_cmd   = 8'hFF;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            if (k == rep_off_at) tx_repeat = 1'b0;
        end
        tx_valid  = 1'b0;
        tx_repeat = 1'b0;
    endtask

    // Expected envelope/carrier from NEC timing: leader 160/80, bit mark 10,
    // bit space 10 or 30, stop 10; repeat codes 160/40/10 every 1920 cycles.
    task automatic build_model(input logic [7:0] a, input logic [7:0] c, input int nrep);
        logic [31:0] w;
        int   k;
        int   st;
        logic prev;
        for (int i = 0; i < NMAX; i++) begin
            exp_env[i] = 1'b0;
            exp_out[i] = 1'b0;
        end
        w = {~c, c, ~a, a};
        for (int i = 0; i < 160; i++) exp_env[i] = 1'b1;
        k = 240;
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < 10; i++) exp_env[k + i] = 1'b1;
            k += w[b] ? 40 : 20;
        end
        for (int i = 0; i < 10; i++) exp_env[k + i] = 1'b1;
        for (int r = 1; r <= nrep; r++) begin
            for (int i = 0; i < 160; i++) exp_env[1920 * r + i] = 1'b1;
            for (int i = 0; i < 10; i++) exp_env[1920 * r + 200 + i] = 1'b1;
        end
        st   = 0;
        prev = 1'b0;
        for (int i = 0; i < NMAX; i++) begin
            if (exp_env[i] && !prev) st = i;
            exp_out[i] = exp_env[i] && (((i - st) % 4) < 2);
            prev = exp_env[i];
        end
    endtask

    function automatic int run_len(input int from, input logic val, input int ncap);
        int n = 0;
        while ((from + n < ncap) && (env_log[from + n] == val)) n++;
        return n;
    endfunction

    function automatic int env_mismatch(input int ncap);
        int n = 0;
        for (int i = 0; i < ncap; i++) if (env_log[i] !== exp_env[i]) n++;
        return n;
    endfunction

    function automatic int out_mismatch(input int ncap);
        int n = 0;
        for (int i = 0; i < ncap; i++) if (out_log[i] !== exp_out[i]) n++;
        return n;
    endfunction

    function automatic int first_ready(input int ncap);
        for (int i = 0; i < ncap; i++) if (rdy_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int first_done(input int ncap);
        for (int i = 0; i < ncap; i++) if (done_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done(input int ncap);
        int n = 0;
        for (int i = 0; i < ncap; i++) if (done_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int last_env_high(input int ncap);
        int n = -1;
        for (int i = 0; i < ncap; i++) if (env_log[i] === 1'b1) n = i;
        return n;
    endfunction

    // Decode 32 bits from the log by space length; counts malformed bits.
    task automatic decode_bits(input int ncap, output logic [31:0] w, output int bad);
        int k = 240;
        int m;
        int s;
        w   = '0;
        bad = 0;
        for (int b = 0; b < 32; b++) begin
            m = 0;
            while ((k < ncap) && env_log[k]) begin m++; k++; end
            s = 0;
            while ((k < ncap) && !env_log[k] && (s < 40)) begin s++; k++; end
            if (m != 10) bad++;
            if (s == 30) w[b] = 1'b1;
            else if (s != 10) bad++;
        end
    endtask

    task automatic test_reset();
        int act;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_addr   = 8'h00;
        tx_cmd    = 8'h00;
        tx_repeat = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        checks++; if (ir_envelope !== 1'b0) begin errors++; $display("FAIL reset_env: got %b expected 0", ir_envelope); end
        checks++; if (ir_tx_out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", ir_tx_out); end
        rst = 1'b0;
        @(negedge clk);
        tx_addr  = 8'hA5;
        tx_cmd   = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (ir_envelope !== 1'b1) begin errors++; $display("FAIL midlead_env: got %b expected 1", ir_envelope); end
        checks++; if (ir_tx_out !== 1'b1) begin errors++; $display("FAIL midlead_out: got %b expected 1", ir_tx_out); end
        rst = 1'b1;
        #1;
        checks++; if (ir_envelope !== 1'b0) begin errors++; $display("FAIL async_rst_env: got %b expected 0", ir_envelope); end
        checks++; if (ir_tx_out !== 1'b0) begin errors++; $display("FAIL async_rst_out: got %b expected 0", ir_tx_out); end
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ir_envelope !== 1'b0 || ir_tx_out !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles expected 0", act); end
    endtask

    task automatic test_single_frame();
        int          n;
        int          bad;
        logic [31:0] w;
        run_frame(8'h00, 8'h16, 1'b0, -1, -1, 2000);
        build_model(8'h00, 8'h16, 0);
        n = run_len(0, 1'b1, 2000);
        checks++; if (n != 160) begin errors++; $display("FAIL lead_mark_len: got %0d expected 160", n); end
        n = run_len(160, 1'b0, 2000);
        checks++; if (n != 80) begin errors++; $display("FAIL lead_space_len: got %0d expected 80", n); end
        decode_bits(2000, w, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL bit_timing: got %0d bad bits expected 0", bad); end
        checks++; if (w[7:0] !== 8'h00) begin errors++; $display("FAIL addr_byte: got %h expected 00", w[7:0]); end
        checks++; if (w[15:8] !== 8'hFF) begin errors++; $display("FAIL naddr_byte: got %h expected ff", w[15:8]); end
        checks++; if (w[23:16] !== 8'h16) begin errors++; $display("FAIL cmd_byte: got %h expected 16", w[23:16]); end
        checks++; if (w[31:24] !== 8'hE9) begin errors++; $display("FAIL ncmd_byte: got %h expected e9", w[31:24]); end
        n = run_len(1200, 1'b1, 2000);
        checks++; if (n != 10) begin errors++; $display("FAIL stop_mark_len: got %0d expected 10", n); end
        n = first_done(2000);
        checks++; if (n != 1209) begin errors++; $display("FAIL done_pos: got %0d expected 1209", n); end
        n = count_done(2000);
        checks++; if (n != 1) begin errors++; $display("FAIL done_count: got %0d expected 1", n); end
        n = first_ready(2000);
        checks++; if (n != 1920) begin errors++; $display("FAIL ready_return: got %0d expected 1920", n); end
        n = env_mismatch(2000);
        checks++; if (n != 0) begin errors++; $display("FAIL env_trace: got %0d bad cycles expected 0", n); end
        n = out_mismatch(2000);
        checks++; if (n != 0) begin errors++; $display("FAIL carrier_trace: got %0d bad cycles expected 0", n); end
        n = 0;
        for (int i = 0; i < 2000; i++) if (out_log[i] && !env_log[i]) n++;
        checks++; if (n != 0) begin errors++; $display("FAIL out_in_space: got %0d cycles expected 0", n); end
    endtask

    task automatic test_busy();
        int n;
        run_frame(8'h12, 8'h34, 1'b0, -1, 500, 2300);
        build_model(8'h12, 8'h34, 0);
        n = env_mismatch(2300);
        checks++; if (n != 0) begin errors++; $display("FAIL busy_env_trace: got %0d bad cycles expected 0", n); end
        n = first_ready(2300);
        checks++; if (n != 1920) begin errors++; $display("FAIL busy_ready: got %0d expected 1920", n); end
        n = 0;
        for (int i = 1920; i < 2300; i++) if (env_log[i]) n++;
        checks++; if (n != 0) begin errors++; $display("FAIL busy_no_second: got %0d mark cycles expected 0", n); end
        n = count_done(2300);
        checks++; if (n != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", n); end
    endtask

    // The complemented bytes give every frame 16 ones and 16 zeros, so both
    // vectors are 121 units (1210 cycles) long.
    task automatic test_extremes();
        logic [7:0] vec [2];
        int n;
        vec[0] = 8'h00;
        vec[1] = 8'hFF;
        for (int v = 0; v < 2; v++) begin
            run_frame(vec[v], vec[v], 1'b0, -1, -1, 2000);
            build_model(vec[v], vec[v], 0);
            n = last_env_high(2000) + 1;
            checks++; if (n != 1210) begin errors++; $display("FAIL ext_len_%h: got %0d expected 1210", vec[v], n); end
            n = first_ready(2000);
            checks++; if (n != 1920) begin errors++; $display("FAIL ext_ready_%h: got %0d expected 1920", vec[v], n); end
            n = env_mismatch(2000);
            checks++; if (n != 0) begin errors++; $display("FAIL ext_env_%h: got %0d bad cycles expected 0", vec[v], n); end
        end
    endtask

    task automatic test_repeat();
        int n;
        run_frame(8'h40, 8'h0C, 1'b1, 4000, -1, 5800);
`ifdef NEC_REPEAT_EN
        build_model(8'h40, 8'h0C, 2);
        n = run_len(1920, 1'b1, 5800);
        checks++; if (n != 160) begin errors++; $display("FAIL rep_mark_len: got %0d expected 160", n); end
        n = run_len(2080, 1'b0, 5800);
        checks++; if (n != 40) begin errors++; $display("FAIL rep_space_len: got %0d expected 40", n); end
        n = run_len(2120, 1'b1, 5800);
        checks++; if (n != 10) begin errors++; $display("FAIL rep_stop_len: got %0d expected 10", n); end
        n = run_len(3840, 1'b1, 5800);
        checks++; if (n != 160) begin errors++; $display("FAIL rep2_mark_len: got %0d expected 160", n); end
        n = count_done(5800);
        checks++; if (n != 3) begin errors++; $display("FAIL rep_done_count: got %0d expected 3", n); end
        n = first_ready(5800);
        checks++; if (n != 5760) begin errors++; $display("FAIL rep_ready: got %0d expected 5760", n); end
`else
        build_model(8'h40, 8'h0C, 0);
        n = count_done(5800);
        checks++; if (n != 1) begin errors++; $display("FAIL norep_done_count: got %0d expected 1", n); end
        n = first_ready(5800);
        checks++; if (n != 1920) begin errors++; $display("FAIL norep_ready: got %0d expected 1920", n); end
`endif
        n = env_mismatch(5800);
        checks++; if (n != 0) begin errors++; $display("FAIL rep_env_trace: got %0d bad cycles expected 0", n); end
        n = out_mismatch(5800);
        checks++; if (n != 0) begin errors++; $display("FAIL rep_carrier_trace: got %0d bad cycles expected 0", n); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy();
        test_extremes();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
